pipe_stage_skid: RTL and testbench

//  Parametrised inter-stage pipeline register (F/D, D/X, X/M, M/W) replacing fixed per-stage latch modules.

---
 rtl/pipe_stage_skid.sv | 152 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: parametrised inter-stage pipeline register with a two-entry skid buffer.
// Carries NFIELDS packed WIDTH-bit fields (field 0 = instruction) with a valid/ready handshake.
// The buffer sustains one entry per cycle, in_ready is registered, and a synchronous flush loads a NOP.
//
// Optional feature: define PIPE_STAGE_PERF_EN to build the saturating stall/flush counters.
// Without it there are no counter flops and both counter ports read 0.
//
// Ports:
//   clk        in   rising-edge clock
//   clr        in   asynchronous active-high reset
//   in_valid   in   upstream presents in_data
//   in_ready   out  stage can accept in_data this cycle (registered)
//   in_data    in   NFIELDS*WIDTH payload, field k at [k*WIDTH +: WIDTH]
//   flush      in   synchronous squash of held and incoming entries
//   out_valid  out  out_data holds a live entry (registered)
//   out_ready  in   downstream consumes out_data this cycle
//   out_data   out  oldest held entry
//   stall_cnt  out  cycles with out_valid & !out_ready (saturating)
//   flush_cnt  out  flush cycles that discarded at least one valid entry (saturating)
module pipe_stage_skid #(
  parameter int unsigned           NFIELDS  = 5,
  parameter int unsigned           WIDTH    = 32,
  parameter logic [WIDTH-1:0]      NOP_INSN = '0,
  parameter int unsigned           CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NFIELDS*WIDTH-1:0]   in_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NFIELDS*WIDTH-1:0]   out_data,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  localparam int unsigned DW = NFIELDS * WIDTH;
  // Field 0 = NOP_INSN, all other fields zero.
  localparam logic [DW-1:0] NOP_WORD = DW'(NOP_INSN);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   main_q, main_d;
  logic [DW-1:0]   skid_q, skid_d;
  logic            accept_c;
  logic            consume_c;

  // Handshake decodes use only registered signals, so in_ready has no path from out_ready.
  assign accept_c  = in_valid & in_ready;
  assign consume_c = out_valid & out_ready;
  assign out_data  = main_q;

  // State and data registers; in_ready/out_valid are flopped copies of the next-state decode.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= EMPTY;
      main_q    <= NOP_WORD;
      skid_q    <= NOP_WORD;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      out_valid <= (state_d != EMPTY);
      in_ready  <= (state_d != FULL);
    end
  end

  // Next state and data; emptied registers are reloaded with the NOP pattern so nothing stale shows.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_WORD;
      skid_d  = NOP_WORD;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept_c) begin
            state_d = BUSY;
            main_d  = in_data;
          end
        end
        BUSY: begin
          if (accept_c && consume_c) begin
            main_d = in_data;
          end else if (accept_c) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (consume_c) begin
            state_d = EMPTY;
            main_d  = NOP_WORD;
          end
        end
        FULL: begin
          if (consume_c) begin
            state_d = BUSY;
            main_d  = skid_q;
            skid_d  = NOP_WORD;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_WORD;
          skid_d  = NOP_WORD;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             stall_hit_c;
  logic             flush_hit_c;

  assign stall_hit_c = out_valid & ~out_ready;
  assign flush_hit_c = flush & ((state_q != EMPTY) | in_valid);

  // Saturating performance counters, cleared only by clr.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_hit_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_hit_c && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: stream, backpressure, flush, async clr and counters.
module tb_pipe_stage_skid;

  localparam int unsigned NF   = 5;
  localparam int unsigned W    = 32;
  localparam int unsigned DW   = NF * W;
  localparam int unsigned CW   = 4;
  localparam logic [W-1:0] NOP = 32'h0000_0013;
  localparam logic [DW-1:0] NOPW = DW'(NOP);
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  int total = 0;
  int bad   = 0;

  pipe_stage_skid #(
    .NFIELDS (NF),
    .WIDTH   (W),
    .NOP_INSN(NOP),
    .CNT_W   (CW)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Payload with field0 = v and each other field tagged with its index.
  function automatic logic [DW-1:0] mk(input logic [W-1:0] v);
    logic [DW-1:0] r;
    for (int k = 0; k < int'(NF); k++) begin
      r[k*W +: W] = (k == 0) ? v : (v | (W'(k) << 24));
    end
    return r;
  endfunction

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_data !== NOPW) begin bad++; $display("FAIL reset_out_data got=%h exp=%h", out_data, NOPW); end
    total++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = mk(W'(i));
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== mk(W'(i))) begin bad++; $display("FAIL stream_%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, mk(W'(i))); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready_%0d got=%b exp=1", i, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0 || out_data !== NOPW) begin bad++; $display("FAIL stream_drain got v=%b d=%h exp v=0 d=%h", out_valid, out_data, NOPW); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = mk(32'h10); tick();
    total++; if (out_data !== mk(32'h10) || in_ready !== 1'b1) begin bad++; $display("FAIL bp_first got d=%h r=%b exp d=%h r=1", out_data, in_ready, mk(32'h10)); end
    in_data = mk(32'h20); tick();
    total++; if (in_ready !== 1'b0 || out_data !== mk(32'h10)) begin bad++; $display("FAIL bp_full got r=%b d=%h exp r=0 d=%h", in_ready, out_data, mk(32'h10)); end
    in_data = mk(32'h30); tick();
    total++; if (in_ready !== 1'b0 || out_data !== mk(32'h10) || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold got r=%b v=%b d=%h exp r=0 v=1 d=%h", in_ready, out_valid, out_data, mk(32'h10)); end
    out_ready = 1'b1; tick();
    total++; if (out_data !== mk(32'h20) || in_ready !== 1'b1) begin bad++; $display("FAIL bp_skid_out got d=%h r=%b exp d=%h r=1", out_data, in_ready, mk(32'h20)); end
    tick();
    total++; if (out_data !== mk(32'h30) || out_valid !== 1'b1) begin bad++; $display("FAIL bp_reaccept got v=%b d=%h exp v=1 d=%h", out_valid, out_data, mk(32'h30)); end
    in_valid = 1'b0; tick();
    total++; if (out_valid !== 1'b0 || out_data !== NOPW) begin bad++; $display("FAIL bp_drain got v=%b d=%h exp v=0 d=%h", out_valid, out_data, NOPW); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = mk(32'h40); tick();
    in_data = mk(32'h50); tick();
    flush = 1'b1; in_data = mk(32'h99); tick();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_flags got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
    total++; if (out_data !== NOPW) begin bad++; $display("FAIL flush_data got=%h exp=%h", out_data, NOPW); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
    total++; if (out_valid !== 1'b0 || out_data !== NOPW) begin bad++; $display("FAIL flush_after got v=%b d=%h exp v=0 d=%h", out_valid, out_data, NOPW); end
    // Flush while consuming from BUSY: entry leaves, stage empties.
    in_valid = 1'b1; in_data = mk(32'h60); tick();
    total++; if (out_data !== mk(32'h60)) begin bad++; $display("FAIL flush_refill got=%h exp=%h", out_data, mk(32'h60)); end
    flush = 1'b1; in_data = mk(32'h61); tick();
    total++; if (out_valid !== 1'b0 || out_data !== NOPW) begin bad++; $display("FAIL flush_busy got v=%b d=%h exp v=0 d=%h", out_valid, out_data, NOPW); end
    flush = 1'b0; in_valid = 1'b0; tick();
  endtask

  task automatic test_async_clr();
    out_ready = 1'b1; in_valid = 1'b1; in_data = mk(32'h70); tick();
    total++; if (out_valid !== 1'b1 || out_data !== mk(32'h70)) begin bad++; $display("FAIL clr_pre got v=%b d=%h exp v=1 d=%h", out_valid, out_data, mk(32'h70)); end
    #2 clr = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== NOPW) begin bad++; $display("FAIL clr_async got v=%b r=%b d=%h exp v=0 r=1 d=%h", out_valid, in_ready, out_data, NOPW); end
    total++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin bad++; $display("FAIL clr_counters got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    // Held across an edge: the valid input must be ignored.
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_held got v=%b exp=0", out_valid); end
    #1 clr = 1'b0; in_data = mk(32'h55);
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== mk(32'h55)) begin bad++; $display("FAIL clr_restart got v=%b d=%h exp v=1 d=%h", out_valid, out_data, mk(32'h55)); end
    in_valid = 1'b0; tick();
  endtask

  task automatic test_counters();
    #1 clr = 1'b1; #1 clr = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'hA0); tick();
    in_valid = 1'b0;
    repeat (10) tick();
    total++; if (stall_cnt !== (PERF ? 4'd10 : 4'd0)) begin bad++; $display("FAIL stall_cnt_10 got=%0d exp=%0d", stall_cnt, PERF ? 10 : 0); end
    repeat (10) tick();
    total++; if (stall_cnt !== (PERF ? 4'd15 : 4'd0)) begin bad++; $display("FAIL stall_cnt_sat got=%0d exp=%0d", stall_cnt, PERF ? 15 : 0); end
    total++; if (out_data !== mk(32'hA0) || out_valid !== 1'b1) begin bad++; $display("FAIL stall_hold got v=%b d=%h exp v=1 d=%h", out_valid, out_data, mk(32'hA0)); end
    flush = 1'b1; tick();
    total++; if (flush_cnt !== (PERF ? 4'd1 : 4'd0)) begin bad++; $display("FAIL flush_cnt_1 got=%0d exp=%0d", flush_cnt, PERF ? 1 : 0); end
    tick();
    total++; if (flush_cnt !== (PERF ? 4'd1 : 4'd0)) begin bad++; $display("FAIL flush_cnt_empty got=%0d exp=%0d", flush_cnt, PERF ? 1 : 0); end
    in_valid = 1'b1; in_data = mk(32'hB0); tick();
    total++; if (flush_cnt !== (PERF ? 4'd2 : 4'd0) || out_valid !== 1'b0) begin bad++; $display("FAIL flush_cnt_inval got=%0d v=%b exp=%0d v=0", flush_cnt, out_valid, PERF ? 2 : 0); end
    total++; if (stall_cnt !== (PERF ? 4'd15 : 4'd0)) begin bad++; $display("FAIL stall_cnt_keep got=%0d exp=%0d", stall_cnt, PERF ? 15 : 0); end
    flush = 1'b0; in_valid = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_clr();
    test_counters();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
